// File: rtl/multi_blink_ctrl.sv
// Multi-channel LED blink controller: NCH channels share one 1 ms tick prescaler,
// each runs OFF / ON / BLINK / BURST from a runtime-written config.
module multi_blink_ctrl #(
    parameter int unsigned F_CLK_HZ = 25_000_000,
    parameter int unsigned NCH      = 4,
    parameter int unsigned MS_W     = 12,
    parameter int unsigned BURST_W  = 8,
    localparam int unsigned CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [1:0]         wr_mode,
    input  logic [MS_W-1:0]    wr_on_ms,
    input  logic [MS_W-1:0]    wr_off_ms,
    input  logic [BURST_W-1:0] wr_burst,
    output logic [NCH-1:0]     led,
    output logic [NCH-1:0]     busy,
    output logic [NCH-1:0]     done
);

    localparam int unsigned TICK_DIV = F_CLK_HZ / 1000;
    localparam int unsigned PC_W     = $clog2(TICK_DIV);

    typedef enum logic [1:0] {StIdle, StOn, StOff} state_t;
    typedef enum logic [1:0] {ModeOff, ModeOn, ModeBlink, ModeBurst} mode_t;

    logic [PC_W-1:0] pcnt_q;
    logic            ms_tick;

    state_t       state_q     [NCH];
    state_t       state_d     [NCH];
    mode_t        mode_q      [NCH];
    mode_t        mode_d      [NCH];
    logic [MS_W-1:0]    on_ms_q     [NCH];
    logic [MS_W-1:0]    on_ms_d     [NCH];
    logic [MS_W-1:0]    off_ms_q    [NCH];
    logic [MS_W-1:0]    off_ms_d    [NCH];
    logic [MS_W-1:0]    ms_cnt_q    [NCH];
    logic [MS_W-1:0]    ms_cnt_d    [NCH];
    logic [BURST_W-1:0] burst_n_q   [NCH];
    logic [BURST_W-1:0] burst_n_d   [NCH];
    logic [BURST_W-1:0] burst_cnt_q [NCH];
    logic [BURST_W-1:0] burst_cnt_d [NCH];
    logic [NCH-1:0]     led_q, led_d, busy_q, busy_d, done_q, done_d;
    logic [MS_W-1:0]    on_last, off_last;

    // Free-running: writes never realign the tick, so the first phase may be short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else if (ms_tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + PC_W'(1);
        end
    end

    assign ms_tick = (pcnt_q == PC_W'(TICK_DIV - 1));

    always_comb begin
        on_last  = '0;
        off_last = '0;
        led_d    = led_q;
        busy_d   = '0;
        done_d   = '0;
        for (int c = 0; c < NCH; c++) begin
            state_d[c]     = state_q[c];
            mode_d[c]      = mode_q[c];
            on_ms_d[c]     = on_ms_q[c];
            off_ms_d[c]    = off_ms_q[c];
            ms_cnt_d[c]    = ms_cnt_q[c];
            burst_n_d[c]   = burst_n_q[c];
            burst_cnt_d[c] = burst_cnt_q[c];
            // A zero phase length behaves as 1 ms.
            on_last  = (on_ms_q[c] == '0) ? '0 : on_ms_q[c] - MS_W'(1);
            off_last = (off_ms_q[c] == '0) ? '0 : off_ms_q[c] - MS_W'(1);

            if (wr_en && (32'(wr_ch) == c)) begin
                mode_d[c]      = mode_t'(wr_mode);
                on_ms_d[c]     = wr_on_ms;
                off_ms_d[c]    = wr_off_ms;
                burst_n_d[c]   = wr_burst;
                ms_cnt_d[c]    = '0;
                burst_cnt_d[c] = '0;
                unique case (mode_t'(wr_mode))
                    ModeOff: begin
                        state_d[c] = StIdle;
                        led_d[c]   = 1'b0;
                    end
                    ModeOn: begin
                        state_d[c] = StIdle;
                        led_d[c]   = 1'b1;
                    end
                    ModeBlink: begin
                        state_d[c] = StOn;
                        led_d[c]   = 1'b1;
                    end
                    ModeBurst: begin
                        if (wr_burst == '0) begin
                            state_d[c] = StIdle;
                            led_d[c]   = 1'b0;
                            done_d[c]  = 1'b1;
                        end else begin
                            state_d[c] = StOn;
                            led_d[c]   = 1'b1;
                        end
                    end
                endcase
            end else if (ms_tick) begin
                case (state_q[c])
                    StOn: begin
                        if (ms_cnt_q[c] == on_last) begin
                            state_d[c]  = StOff;
                            ms_cnt_d[c] = '0;
                            led_d[c]    = 1'b0;
                        end else begin
                            ms_cnt_d[c] = ms_cnt_q[c] + MS_W'(1);
                        end
                    end
                    StOff: begin
                        if (ms_cnt_q[c] == off_last) begin
                            ms_cnt_d[c] = '0;
                            if (mode_q[c] == ModeBurst) begin
                                burst_cnt_d[c] = burst_cnt_q[c] + BURST_W'(1);
                                if (burst_cnt_q[c] == burst_n_q[c] - BURST_W'(1)) begin
                                    state_d[c] = StIdle;
                                    led_d[c]   = 1'b0;
                                    done_d[c]  = 1'b1;
                                end else begin
                                    state_d[c] = StOn;
                                    led_d[c]   = 1'b1;
                                end
                            end else begin
                                state_d[c] = StOn;
                                led_d[c]   = 1'b1;
                            end
                        end else begin
                            ms_cnt_d[c] = ms_cnt_q[c] + MS_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
            busy_d[c] = (state_d[c] != StIdle);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                state_q[c]     <= StIdle;
                mode_q[c]      <= ModeOff;
                on_ms_q[c]     <= '0;
                off_ms_q[c]    <= '0;
                ms_cnt_q[c]    <= '0;
                burst_n_q[c]   <= '0;
                burst_cnt_q[c] <= '0;
            end
        end else begin
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
            for (int c = 0; c < NCH; c++) begin
                state_q[c]     <= state_d[c];
                mode_q[c]      <= mode_d[c];
                on_ms_q[c]     <= on_ms_d[c];
                off_ms_q[c]    <= off_ms_d[c];
                ms_cnt_q[c]    <= ms_cnt_d[c];
                burst_n_q[c]   <= burst_n_d[c];
                burst_cnt_q[c] <= burst_cnt_d[c];
            end
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_multi_blink_ctrl.sv
// Bench for multi_blink_ctrl: a per-channel countdown model predicts led/busy/done every
// clock into a queue; a monitor on the falling edge pops and compares.
module tb_multi_blink_ctrl;

    localparam int NCH = 4;
    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_ch = '0;
    logic [1:0] wr_mode = '0;
    logic [3:0] wr_on_ms = '0;
    logic [3:0] wr_off_ms = '0;
    logic [2:0] wr_burst = '0;
    logic [3:0] led, busy, done;

    multi_blink_ctrl #(
        .F_CLK_HZ(8000),
        .NCH     (4),
        .MS_W    (4),
        .BURST_W (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_ch    (wr_ch),
        .wr_mode  (wr_mode),
        .wr_on_ms (wr_on_ms),
        .wr_off_ms(wr_off_ms),
        .wr_burst (wr_burst),
        .led      (led),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [11:0] sb[$];

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at %0t: got %b, want %b", nm, $time, act, expv);
        end
    endtask

    // Reference model: phase = 0 idle, 1 on, 2 off; rem = ms ticks left in the phase;
    // left = burst periods still to complete.
    int m_ph[NCH], m_rem[NCH], m_left[NCH], m_mode[NCH], m_on[NCH], m_off[NCH];
    bit m_led[NCH];
    int n_edges;

    always @(posedge clk) begin : model
        logic [3:0] e_led, e_busy, e_done;
        bit tick;
        e_led  = '0;
        e_busy = '0;
        e_done = '0;
        if (rst) begin
            n_edges = 0;
            for (int c = 0; c < NCH; c++) begin
                m_ph[c]  = 0;
                m_led[c] = 1'b0;
            end
        end else begin
            tick = ((n_edges % DIV) == DIV - 1);
            n_edges++;
            for (int c = 0; c < NCH; c++) begin
                if (wr_en && int'(wr_ch) == c) begin
                    m_on[c]   = (wr_on_ms == 0) ? 1 : int'(wr_on_ms);
                    m_off[c]  = (wr_off_ms == 0) ? 1 : int'(wr_off_ms);
                    m_mode[c] = int'(wr_mode);
                    m_left[c] = int'(wr_burst);
                    case (m_mode[c])
                        0: begin m_ph[c] = 0; m_led[c] = 1'b0; end
                        1: begin m_ph[c] = 0; m_led[c] = 1'b1; end
                        2: begin m_ph[c] = 1; m_rem[c] = m_on[c]; m_led[c] = 1'b1; end
                        default: begin
                            if (m_left[c] == 0) begin
                                m_ph[c] = 0; m_led[c] = 1'b0; e_done[c] = 1'b1;
                            end else begin
                                m_ph[c] = 1; m_rem[c] = m_on[c]; m_led[c] = 1'b1;
                            end
                        end
                    endcase
                end else if (tick && m_ph[c] != 0) begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        if (m_ph[c] == 1) begin
                            m_ph[c] = 2; m_rem[c] = m_off[c]; m_led[c] = 1'b0;
                        end else begin
                            if (m_mode[c] == 3) m_left[c]--;
                            if (m_mode[c] == 3 && m_left[c] == 0) begin
                                m_ph[c] = 0; m_led[c] = 1'b0; e_done[c] = 1'b1;
                            end else begin
                                m_ph[c] = 1; m_rem[c] = m_on[c]; m_led[c] = 1'b1;
                            end
                        end
                    end
                end
                e_led[c]  = m_led[c];
                e_busy[c] = (m_ph[c] != 0);
            end
        end
        sb.push_back({e_led, e_busy, e_done});
    end

    always @(negedge clk) begin : monitor
        logic [11:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("led", led, e[11:8]);
            check("busy", busy, e[7:4]);
            check("done", done, e[3:0]);
        end
    end

    task automatic wr(input int ch, input int md, input int on, input int off, input int b);
        @(negedge clk);
        #1;
        wr_en     = 1'b1;
        wr_ch     = 2'(ch);
        wr_mode   = 2'(md);
        wr_on_ms  = 4'(on);
        wr_off_ms = 4'(off);
        wr_burst  = 3'(b);
        @(negedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        idle(5);

        wr(0, 2, 2, 3, 0);        // blink 2/3 on ch0
        idle(100);
        wr(1, 3, 1, 1, 3);        // burst of 3 on ch1
        idle(80);
        wr(2, 3, 5, 5, 0);        // zero-length burst on ch2
        idle(10);
        wr(1, 3, 2, 2, 7);
        idle(30);
        wr(1, 1, 0, 0, 0);        // abort burst mid-way with solid ON
        idle(50);
        wr(3, 2, 0, 0, 0);        // zero times behave as 1 ms
        idle(40);

        // Asynchronous reset while channels are active.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_led", led, 4'b0);
        check("rst_busy", busy, 4'b0);
        check("rst_done", done, 4'b0);
        idle(3);
        #1 rst = 1'b0;
        idle(40);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) begin
                wr($urandom_range(3), $urandom_range(3), $urandom_range(15),
                   $urandom_range(15), $urandom_range(7));
            end else begin
                idle(1);
            end
        end
        idle(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
